btn_pulse_gen: RTL

- Input-side companion to the board's seven-segment output path. It turns raw, bouncy push-buttons into clean per-button level and single-cycle event pulses.
- Per button: 2-flop synchronizer, debounce counter, press/release pulse generator, and optional hold-to-auto-repeat.
- Sits between the board `btn` pins and the Turing-machine control inputs (`Next`, `Done`, etc.).
- Replaces bare synchronizers, so one physical press yields exactly one step.

---
 rtl/btn_pkg.sv | 28 ++
 rtl/btn_channel.sv | 129 ++++++++++++
 rtl/btn_pulse_gen.sv | 44 ++++
 3 files changed

// File: rtl/btn_pkg.sv
//------------------------------------------------------------------------------
// Module      : btn_pkg
// Description : Shared channel state encoding and counter sizing for the
//               push-button pulse generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package btn_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      HOLD_DELAY  = 2'd1,
      HOLD_REPEAT = 2'd2
   } btn_state_t;

   // One width covers both the debounce and the repeat counter.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
//------------------------------------------------------------------------------
// Module      : btn_channel
// Description : One button: 2-flop synchronizer, debounce, press/release
//               pulses and hold-to-auto-repeat.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_async,
   input  logic repeat_en,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] c_deb_lim = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] c_dly_lim = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] c_per_lim = CW'(REPEAT_PERIOD);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic          r_release;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_rcnt;
   btn_state_t    r_state;

   logic [CW-1:0] w_cnt_inc;
   logic [CW-1:0] w_rcnt_inc;
   logic [CW-1:0] w_rcnt_next;
   logic [CW-1:0] w_lim;
   logic          w_flip;
   logic          w_rise;
   logic          w_fall;
   logic          w_press_next;
   logic          w_release_next;
   btn_state_t    w_state_next;

   assign w_cnt_inc  = r_cnt + CW'(1);
   assign w_rcnt_inc = r_rcnt + CW'(1);
   assign w_flip     = (r_sync2 != r_level) && (w_cnt_inc == c_deb_lim);
   assign w_rise     = w_flip && r_sync2;
   assign w_fall     = w_flip && !r_sync2;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_cnt     <= '0;
         r_rcnt    <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_state   <= RELEASED;
      end else begin
         r_sync1 <= btn_async;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
         end else begin
            r_cnt <= w_cnt_inc;
         end
         r_rcnt    <= w_rcnt_next;
         r_press   <= w_press_next;
         r_release <= w_release_next;
         r_state   <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_rcnt_next    = r_rcnt;
      w_press_next   = 1'b0;
      w_release_next = 1'b0;
      w_lim          = (r_state == HOLD_REPEAT) ? c_per_lim : c_dly_lim;
      case (r_state)
         RELEASED: begin
            if (w_rise) begin
               w_press_next = 1'b1;
               w_rcnt_next  = '0;
               w_state_next = HOLD_DELAY;
            end
         end
         HOLD_DELAY, HOLD_REPEAT: begin
            // A release wins over a repeat falling due on the same edge.
            if (w_fall) begin
               w_release_next = 1'b1;
               w_rcnt_next    = '0;
               w_state_next   = RELEASED;
            end else if ((r_rcnt == w_lim) || (w_rcnt_inc == w_lim)) begin
               if (repeat_en) begin
                  w_press_next = 1'b1;
                  w_rcnt_next  = '0;
                  w_state_next = HOLD_REPEAT;
               end else begin
                  w_rcnt_next = w_lim;
               end
            end else begin
               w_rcnt_next = w_rcnt_inc;
            end
         end
         default: begin
            w_rcnt_next  = '0;
            w_state_next = RELEASED;
         end
      endcase
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;

endmodule

`default_nettype wire

// File: rtl/btn_pulse_gen.sv
//------------------------------------------------------------------------------
// Module      : btn_pulse_gen
// Description : N_BTN independent debounced button channels with level,
//               press/auto-repeat and release outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_async,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clock       (clock),
         .reset       (reset),
         .btn_async   (btn_async[i]),
         .repeat_en   (repeat_en[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i])
      );
   end

endmodule

`default_nettype wire
